// File: rtl/bcd_err_monitor_if.sv
// Sample bus for bcd_err_monitor.
//   master : BCD source side; drives in_valid/in_digits, observes the check result
//   slave  : monitor side; receives the sample, returns out_valid/digit_err/any_err
interface bcd_err_monitor_if #(
  parameter int DIGITS = 2
) ();
  logic                  in_valid;
  logic [4*DIGITS-1:0]   in_digits;
  logic                  out_valid;
  logic [DIGITS-1:0]     digit_err;
  logic                  any_err;

  modport master (
    output in_valid, in_digits,
    input  out_valid, digit_err, any_err
  );

  modport slave (
    input  in_valid, in_digits,
    output out_valid, digit_err, any_err
  );
endinterface

// File: rtl/bcd_err_monitor.sv
// BCD digit validity monitor.
// Checks every accepted sample of DIGITS packed BCD digits for values above 9,
// keeps sticky per-digit flags and a saturating erroneous-sample count, and
// escalates to a latched fault after THRESH consecutive erroneous samples.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : slave side of the sample bus (in_valid, in_digits in;
//                out_valid, digit_err, any_err out)
//   clear      : synchronous clear of flags, counters and FSM; beats in_valid
//   sticky_err : per-digit OR of digit_err since reset/clear
//   err_count  : erroneous samples seen, saturating
//   state      : 0 OK, 1 SUSPECT, 2 FAULT
//   fault      : high exactly in FAULT
//
// state   | meaning
// --------+-------------------------------------------------------
// OK      | no erroneous sample in the current run
// SUSPECT | run of erroneous samples shorter than THRESH
// FAULT   | THRESH consecutive erroneous samples seen; latched
module bcd_err_monitor #(
  parameter int DIGITS = 2,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_err_monitor_if.slave      bus,
  input  logic                  clear,
  output logic [DIGITS-1:0]     sticky_err,
  output logic [CNT_W-1:0]      err_count,
  output logic [1:0]            state,
  output logic                  fault
);

  localparam int RUN_W = (THRESH < 1) ? 1 : $clog2(THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(THRESH);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DIGITS-1:0]   digit_err_q, digit_err_d;
  logic                any_err_q, any_err_d;
  logic [DIGITS-1:0]   sticky_err_q, sticky_err_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                fault_q, fault_d;

  logic [DIGITS-1:0]   digit_err_c;
  logic                sample_err;

  always_comb begin
    digit_err_c = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit_err_c[k] = (bus.in_digits[4*k +: 4] > 4'd9);
    end
  end

  assign sample_err = |digit_err_c;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    digit_err_d  = digit_err_q;
    any_err_d    = any_err_q;
    sticky_err_d = sticky_err_q;
    err_count_d  = err_count_q;
    run_d        = run_q;

    if (clear) begin
      // digit_err/any_err are deliberately left holding: they describe the
      // last accepted sample, and the sample alongside clear is discarded.
      state_d      = ST_OK;
      sticky_err_d = '0;
      err_count_d  = '0;
      run_d        = '0;
    end else if (bus.in_valid) begin
      out_valid_d  = 1'b1;
      digit_err_d  = digit_err_c;
      any_err_d    = sample_err;
      sticky_err_d = sticky_err_q | digit_err_c;

      if (sample_err) begin
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (run_q != RUN_MAX) begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = '0;
      end

      case (state_q)
        ST_OK: begin
          if (sample_err) begin
            state_d = (THRESH == 1) ? ST_FAULT : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (!sample_err) begin
            state_d = ST_OK;
          end else if (run_d == RUN_MAX) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_OK;
      endcase
    end

    // Registered so fault is a clean flop output aligned with state.
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_OK;
      out_valid_q  <= 1'b0;
      digit_err_q  <= '0;
      any_err_q    <= 1'b0;
      sticky_err_q <= '0;
      err_count_q  <= '0;
      run_q        <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      digit_err_q  <= digit_err_d;
      any_err_q    <= any_err_d;
      sticky_err_q <= sticky_err_d;
      err_count_q  <= err_count_d;
      run_q        <= run_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.digit_err = digit_err_q;
  assign bus.any_err   = any_err_q;
  assign sticky_err    = sticky_err_q;
  assign err_count     = err_count_q;
  assign state         = state_q;
  assign fault         = fault_q;

endmodule

// File: doc/bcd_err_monitor.md
# bcd_err_monitor

Parametrised, clocked BCD digit validity monitor for the display/BCD datapath. Each valid input word carries DIGITS packed 4-bit BCD digits. The block flags any digit above 9 and keeps sticky per-digit error flags and a saturating error-sample counter. A three-state FSM escalates to a latched fault after THRESH consecutive erroneous samples. It replaces the fixed two-digit combinational checker and sits between the BCD source and the 7-segment decoders.

## Interface

**Parameters**
- `DIGITS`, default 2: number of packed BCD digits per sample; must be at least 1.
- `CNT_W`, default 8: width of the error-sample counter.
- `THRESH`, default 3: consecutive erroneous samples that trigger FAULT; must be at least 1.

**Ports**
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: qualifies `in_digits` this cycle.
- `in_digits` in 4*DIGITS: digit k occupies bits [4k+3:4k]; digit 0 is the least significant.
- `clear` in 1: synchronous clear of the sticky flags, the counters and the FSM.
- `out_valid` in the output direction, 1 bit: high for one cycle per accepted sample.
- `digit_err` out DIGITS: per-digit error for the last accepted sample; bit k = (digit k > 9).
- `any_err` out 1: OR of `digit_err`; qualified by `out_valid`.
- `sticky_err` out DIGITS: per-digit OR of every `digit_err` since the last reset or clear.
- `err_count` out CNT_W: number of erroneous samples, saturating at 2^CNT_W−1.
- `state` out 2: 0 = OK, 1 = SUSPECT, 2 = FAULT.
- `fault` out 1: high exactly when `state` is FAULT.

## Operation

- **Per-digit check:** a digit is erroneous when its value is in 10..15. A sample is erroneous when any of its digits is erroneous.
- **Accepted sample:** an accepted sample is a cycle with `in_valid`=1 and `clear`=0. All registers advance only on accepted samples. When `in_valid`=0, every register holds, except `out_valid`, which returns to 0.
- **Run counter:** an internal counter, just wide enough to hold THRESH, tracks consecutive erroneous samples.
  - An erroneous sample increments it, saturating at THRESH.
  - A clean accepted sample zeroes it.
  - Idle cycles do not break a run.
- **FSM transitions** (evaluated on accepted samples only):
  - OK → SUSPECT on an erroneous sample when THRESH>1.
  - OK → FAULT on an erroneous sample when THRESH=1.
  - SUSPECT → FAULT when the updated run count equals THRESH.
  - SUSPECT → OK on a clean sample.
  - FAULT holds regardless of input until `clear` or reset.
- **Error counter:** `err_count` increments by 1 per erroneous sample and saturates; it never wraps.
- **Sticky flags:** `sticky_err` ORs in `digit_err` on every accepted sample.
- **`clear`:**
  - Zeroes `sticky_err`, `err_count` and the run counter, and sets `state` to OK.
  - Forces `out_valid`=0.
  - A sample presented in the same cycle is discarded: it is not checked, counted or flagged. `clear` has priority over `in_valid`.
- **Reset:** reset (`rst_n`=0 at a rising edge) has priority over everything. All outputs and internal state go to 0, so `state` is OK and `fault`=0.

## Timing

- **Latency:** one cycle. A sample accepted at edge N produces `out_valid`, `digit_err`, `any_err`, `sticky_err`, `err_count`, `state` and `fault` valid after edge N.
- **Update cadence:** full throughput; a new sample can be accepted every cycle, with no backpressure.
- **Output hold:** `digit_err` and `any_err` hold their last value while `out_valid`=0.
- **Reset values:** every output is 0 after a reset edge.
- **Reset mid-operation:** a reset during FAULT or SUSPECT returns to OK at that edge. A sample present at that edge is discarded.
- **Combinational paths:** none from any input to any output; all outputs are registered.

## Test plan

1. Reset, then `in_digits`=0x09 with `in_valid`=1 (DIGITS=2) → next cycle: `out_valid`=1, `digit_err`=00, `err_count`=0, `state`=OK.
2. `in_digits`=0xA3 → `digit_err`=10, `any_err`=1, `sticky_err`=10, `err_count`=1, `state`=SUSPECT. Then 0x3F → `digit_err`=01, `sticky_err`=11. Then 0x12 → `state`=OK, `err_count`=2.
3. With THRESH=3, send three erroneous samples separated by idle cycles → `fault`=1 after the third. Then send clean samples → `fault` stays 1 and `err_count`=3.
4. `clear`=1 with `in_valid`=1 and `in_digits`=0xFF → `out_valid`=0, `sticky_err`=00, `err_count`=0, `state`=OK.
5. With CNT_W=2, send 5 erroneous samples → `err_count` reads 1, 2, 3, 3, 3 (no wrap).
6. In FAULT, drive `rst_n`=0 for one edge with `in_valid`=1 and `in_digits`=0xBB → all outputs 0. Then 0x00 → `state`=OK and `digit_err`=00.
